tlb_assoc: RTL and testbench

- Parametrised, fully associative translation lookaside buffer. Next generation of the instruction-side TLB; used for both fetch and data paths.
- Adds over the previous generation:
  - configurable entry count and address widths
  - ASID tagging with a per-entry global bit
  - registered request/response handshake
  - saturating-age replacement
  - duplicate-free refill
  - full and per-ASID flush
- Sits between the core address generator and the memory interface; the page-table walker drives refills on miss.

---
 rtl/tlb_assoc.sv | 173 +++++++++++++++++
 tb/tb_tlb_assoc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_assoc.sv
// Fully associative TLB with ASID tagging and global pages. Lookups are registered.
// Refills replace duplicates in place, else the lowest free slot, else the oldest entry.
module tlb_assoc #(
  parameter int N        = 16,
  parameter int VADDR_W  = 32,
  parameter int PADDR_W  = 20,
  parameter int OFFSET_W = 12,
  parameter int ASID_W   = 8,
  parameter int AGE_W    = 4,
  localparam int VPN_W   = VADDR_W - OFFSET_W,
  localparam int PPN_W   = PADDR_W - OFFSET_W,
  localparam int OCC_W   = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                mode,
  input  logic [ASID_W-1:0]   asid,
  input  logic [VADDR_W-1:0]  vaddr,
  output logic                resp_valid,
  output logic                hit,
  output logic                miss,
  output logic [PADDR_W-1:0]  paddr,
  input  logic                write_en,
  input  logic [VPN_W-1:0]    write_vpn,
  input  logic [PPN_W-1:0]    write_ppn,
  input  logic [ASID_W-1:0]   write_asid,
  input  logic                write_global,
  input  logic                flush_all,
  input  logic                flush_asid_en,
  input  logic [ASID_W-1:0]   flush_asid,
  output logic [OCC_W-1:0]    occupancy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // Handshake: req_valid is sampled on every edge with no backpressure; resp_valid
  // pulses for exactly the following cycle, and hit/miss/paddr hold between responses.

  logic [N-1:0]        valid_q;
  logic [N-1:0]        glob_q;
  logic [VPN_W-1:0]    vpn_q  [N];
  logic [PPN_W-1:0]    ppn_q  [N];
  logic [ASID_W-1:0]   asid_q [N];
  logic [AGE_W-1:0]    age_q  [N];

  logic [VPN_W-1:0]    lk_vpn;
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic [N-1:0]        kill;
  logic [N-1:0]        post_valid;
  logic                wr_match;
  logic [IDX_W-1:0]    wr_match_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    old_idx;
  logic [AGE_W-1:0]    old_age;
  logic [IDX_W-1:0]    victim;
  logic [N-1:0]        next_valid;
  logic [OCC_W-1:0]    occ_next;
  logic                user_lookup;

  assign lk_vpn      = vaddr[VADDR_W-1:OFFSET_W];
  assign user_lookup = req_valid && !mode;

  // Lookup against the pre-edge table; descending scan leaves the lowest match.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_q[i] && vpn_q[i] == lk_vpn && (glob_q[i] || asid_q[i] == asid)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    kill = '0;
    for (int i = 0; i < N; i++) begin
      kill[i] = flush_all || (flush_asid_en && !glob_q[i] && asid_q[i] == flush_asid);
    end
    post_valid = valid_q & ~kill;
  end

  // Victim selection sees the post-flush valid bits so a same-edge refill survives.
  always_comb begin
    wr_match     = 1'b0;
    wr_match_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    old_idx      = '0;
    old_age      = age_q[0];
    for (int i = N - 1; i >= 0; i--) begin
      if (post_valid[i] && vpn_q[i] == write_vpn && (glob_q[i] || asid_q[i] == write_asid)) begin
        wr_match     = 1'b1;
        wr_match_idx = IDX_W'(i);
      end
      if (!post_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 1; i < N; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
    if (wr_match)        victim = wr_match_idx;
    else if (free_found) victim = free_idx;
    else                 victim = old_idx;
  end

  always_comb begin
    next_valid = post_valid;
    if (write_en) next_valid[victim] = 1'b1;
    occ_next = '0;
    for (int i = 0; i < N; i++) begin
      occ_next = occ_next + OCC_W'(next_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      paddr      <= '0;
      occupancy  <= '0;
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        if (mode) begin
          hit   <= 1'b1;
          miss  <= 1'b0;
          paddr <= vaddr[PADDR_W-1:0];
        end else if (lk_hit) begin
          hit   <= 1'b1;
          miss  <= 1'b0;
          paddr <= {ppn_q[lk_idx], vaddr[OFFSET_W-1:0]};
        end else begin
          hit   <= 1'b0;
          miss  <= 1'b1;
          paddr <= {{PPN_W{1'b0}}, vaddr[OFFSET_W-1:0]};
        end
      end
      for (int i = 0; i < N; i++) begin
        if (write_en && victim == IDX_W'(i)) begin
          age_q[i] <= '0;
        end else if (user_lookup && valid_q[i]) begin
          if (lk_hit && lk_idx == IDX_W'(i)) age_q[i] <= '0;
          else if (age_q[i] != AGE_MAX)      age_q[i] <= age_q[i] + 1'b1;
        end
      end
      valid_q   <= next_valid;
      occupancy <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      vpn_q[victim]  <= write_vpn;
      ppn_q[victim]  <= write_ppn;
      asid_q[victim] <= write_asid;
      glob_q[victim] <= write_global;
    end
  end

endmodule

// File: tb/tb_tlb_assoc.sv
// Bench for tlb_assoc: directed scenarios from the plan plus a randomized phase,
// all checked against a table-of-entries reference model.
module tb_tlb_assoc;

  localparam int N = 16;
  localparam int AGE_MAX = 15;

  logic        clk, rst;
  logic        req_valid, mode;
  logic [7:0]  asid;
  logic [31:0] vaddr;
  logic        resp_valid, hit, miss;
  logic [19:0] paddr;
  logic        write_en;
  logic [19:0] write_vpn;
  logic [7:0]  write_ppn;
  logic [7:0]  write_asid;
  logic        write_global;
  logic        flush_all, flush_asid_en;
  logic [7:0]  flush_asid;
  logic [4:0]  occupancy;

  int errors = 0;
  int checks = 0;

  tlb_assoc dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mode(mode), .asid(asid),
    .vaddr(vaddr), .resp_valid(resp_valid), .hit(hit), .miss(miss), .paddr(paddr),
    .write_en(write_en), .write_vpn(write_vpn), .write_ppn(write_ppn),
    .write_asid(write_asid), .write_global(write_global), .flush_all(flush_all),
    .flush_asid_en(flush_asid_en), .flush_asid(flush_asid), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    bit g;
    int vpn;
    int ppn;
    int asid;
    int age;
  } ent_t;

  ent_t        tbl[N];
  bit          exp_rv, exp_hit, exp_miss;
  logic [19:0] exp_paddr;
  int          exp_occ;

  function automatic int find_entry(int vpn, int a);
    for (int i = 0; i < N; i++)
      if (tbl[i].v && tbl[i].vpn == vpn && (tbl[i].g || tbl[i].asid == a)) return i;
    return -1;
  endfunction

  task automatic model_step();
    ent_t old[N];
    int li, w;
    if (rst) begin
      foreach (tbl[i]) begin tbl[i].v = 0; tbl[i].age = 0; end
      exp_rv = 0; exp_hit = 0; exp_miss = 0; exp_paddr = '0; exp_occ = 0;
      return;
    end
    old = tbl;
    li = -1;
    exp_rv = req_valid;
    if (req_valid) begin
      if (mode) begin
        exp_hit = 1; exp_miss = 0; exp_paddr = vaddr[19:0];
      end else begin
        li = find_entry(int'(vaddr[31:12]), int'(asid));
        exp_hit  = (li >= 0);
        exp_miss = (li < 0);
        exp_paddr = (li >= 0) ? 20'((old[li].ppn << 12) | int'(vaddr[11:0])) : {8'h0, vaddr[11:0]};
      end
    end
    foreach (tbl[i])
      if (flush_all || (flush_asid_en && !tbl[i].g && tbl[i].asid == int'(flush_asid))) tbl[i].v = 0;
    w = -1;
    if (write_en) begin
      w = find_entry(int'(write_vpn), int'(write_asid));
      if (w < 0) for (int i = N - 1; i >= 0; i--) if (!tbl[i].v) w = i;
      if (w < 0) begin
        w = 0;
        for (int i = 1; i < N; i++) if (old[i].age > old[w].age) w = i;
      end
    end
    if (req_valid && !mode)
      foreach (tbl[i])
        if (old[i].v) tbl[i].age = (i == li) ? 0 : ((old[i].age < AGE_MAX) ? old[i].age + 1 : AGE_MAX);
    if (w >= 0)
      tbl[w] = '{1'b1, write_global, int'(write_vpn), int'(write_ppn), int'(write_asid), 0};
    exp_occ = 0;
    foreach (tbl[i]) if (tbl[i].v) exp_occ++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst = 0; req_valid = 0; mode = 0; asid = '0; vaddr = '0;
    write_en = 0; write_vpn = '0; write_ppn = '0; write_asid = '0; write_global = 0;
    flush_all = 0; flush_asid_en = 0; flush_asid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic refill(input int vpn, input int ppn, input int a, input bit g);
    @(negedge clk);
    idle_inputs();
    write_en = 1; write_vpn = 20'(vpn); write_ppn = 8'(ppn); write_asid = 8'(a); write_global = g;
    tick();
  endtask

  task automatic lookup(input logic [31:0] va, input int a, input bit m);
    @(negedge clk);
    idle_inputs();
    req_valid = 1; vaddr = va; asid = 8'(a); mode = m;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1; req_valid = 1; vaddr = 32'h0001_2ABC; asid = 8'd3;
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if ({hit, miss} !== 2'b00) begin errors++; $display("FAIL reset_hit_miss: got %b%b want 00", hit, miss); end
    checks++; if (paddr !== 20'h0) begin errors++; $display("FAIL reset_paddr: got %h want 00000", paddr); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_first_miss();
    lookup(32'h0001_2ABC, 3, 0);
    checks++; if ({resp_valid, hit, miss} !== 3'b101) begin errors++; $display("FAIL first_miss_flags: got rv=%b hit=%b miss=%b want 1 0 1", resp_valid, hit, miss); end
    checks++; if (paddr !== 20'h00ABC) begin errors++; $display("FAIL first_miss_paddr: got %h want 00abc", paddr); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL first_miss_occ: got %0d want 0", occupancy); end
    @(negedge clk); idle_inputs(); tick();
    checks++; if ({resp_valid, miss} !== 2'b01) begin errors++; $display("FAIL idle_hold: got rv=%b miss=%b want rv=0 miss=1", resp_valid, miss); end
  endtask

  task automatic test_refill_hit();
    refill(32'h12, 32'h45, 3, 0);
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL refill_occ: got %0d want 1", occupancy); end
    lookup(32'h0001_2ABC, 3, 0);
    checks++; if ({resp_valid, hit, miss} !== 3'b110 || paddr !== 20'h45ABC) begin errors++; $display("FAIL asid_hit: got rv=%b hit=%b paddr=%h want 1 1 45abc", resp_valid, hit, paddr); end
    lookup(32'h0001_2ABC, 4, 0);
    checks++; if ({hit, miss} !== 2'b01 || paddr !== 20'h00ABC) begin errors++; $display("FAIL other_asid_miss: got hit=%b miss=%b paddr=%h want 0 1 00abc", hit, miss, paddr); end
  endtask

  task automatic test_replacement();
    do_reset();
    for (int v = 0; v < N; v++) refill(v, 8'h80 + v, 1, 0);
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ: got %0d want 16", occupancy); end
    for (int r = 0; r < 2; r++)
      for (int v = 1; v < N; v++) begin
        lookup({20'(v), 12'h123}, 1, 0);
        checks++; if (hit !== 1'b1 || paddr !== {8'(8'h80 + v), 12'h123}) begin errors++; $display("FAIL full_hit_%0d: got hit=%b paddr=%h want 1 %h", v, hit, paddr, {8'(8'h80 + v), 12'h123}); end
      end
    checks++; if (tbl[0].age !== AGE_MAX) begin errors++; $display("FAIL model_age0: got %0d want 15", tbl[0].age); end
    refill(32'h100, 32'h5A, 1, 0);
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL evict_occ: got %0d want 16", occupancy); end
    lookup(32'h0000_0777, 1, 0);
    checks++; if (miss !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL evicted_vpn0: got hit=%b miss=%b want 0 1", hit, miss); end
    lookup(32'h0010_0777, 1, 0);
    checks++; if (hit !== 1'b1 || paddr !== 20'h5A777) begin errors++; $display("FAIL new_vpn100: got hit=%b paddr=%h want 1 5a777", hit, paddr); end
    lookup(32'h0000_1777, 1, 0);
    checks++; if (hit !== 1'b1 || paddr !== 20'h81777) begin errors++; $display("FAIL kept_vpn1: got hit=%b paddr=%h want 1 81777", hit, paddr); end
  endtask

  task automatic test_overwrite();
    do_reset();
    refill(32'h20, 32'h11, 2, 0);
    refill(32'h20, 32'h22, 2, 0);
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL dup_occ: got %0d want 1", occupancy); end
    lookup(32'h0002_0FED, 2, 0);
    checks++; if (hit !== 1'b1 || paddr !== 20'h22FED) begin errors++; $display("FAIL dup_ppn: got hit=%b paddr=%h want 1 22fed", hit, paddr); end
  endtask

  task automatic test_flush();
    do_reset();
    refill(32'h30, 32'h01, 5, 0);
    refill(32'h31, 32'h02, 5, 1);
    refill(32'h32, 32'h03, 6, 0);
    checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL pre_flush_occ: got %0d want 3", occupancy); end
    @(negedge clk); idle_inputs(); flush_asid_en = 1; flush_asid = 8'd5; tick();
    checks++; if (occupancy !== 5'd2) begin errors++; $display("FAIL asid_flush_occ: got %0d want 2", occupancy); end
    lookup(32'h0003_0000, 5, 0);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL flushed_entry: got miss=%b want 1", miss); end
    lookup(32'h0003_1004, 7, 0);
    checks++; if (hit !== 1'b1 || paddr !== 20'h02004) begin errors++; $display("FAIL global_kept: got hit=%b paddr=%h want 1 02004", hit, paddr); end
    lookup(32'h0003_2008, 6, 0);
    checks++; if (hit !== 1'b1 || paddr !== 20'h03008) begin errors++; $display("FAIL asid6_kept: got hit=%b paddr=%h want 1 03008", hit, paddr); end
    @(negedge clk); idle_inputs();
    flush_all = 1; flush_asid_en = 1; flush_asid = 8'd6;
    write_en = 1; write_vpn = 20'h40; write_ppn = 8'h07; write_asid = 8'd6;
    tick();
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL flush_refill_occ: got %0d want 1", occupancy); end
    lookup(32'h0004_0ABC, 6, 0);
    checks++; if (hit !== 1'b1 || paddr !== 20'h07ABC) begin errors++; $display("FAIL flush_refill_hit: got hit=%b paddr=%h want 1 07abc", hit, paddr); end
    lookup(32'h0003_2000, 6, 0);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL flush_all_gone: got miss=%b want 1", miss); end
  endtask

  task automatic test_supervisor();
    do_reset();
    lookup(32'hFFF1_2345, 0, 1);
    checks++; if ({resp_valid, hit, miss} !== 3'b110 || paddr !== 20'h12345) begin errors++; $display("FAIL supervisor: got rv=%b hit=%b miss=%b paddr=%h want 1 1 0 12345", resp_valid, hit, miss, paddr); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL supervisor_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      idle_inputs();
      req_valid = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 7) == 0);
      asid      = 8'($urandom_range(0, 3));
      vaddr     = {20'($urandom_range(0, 11)), 12'($urandom)};
      write_en     = ($urandom_range(0, 2) == 0);
      write_vpn    = 20'($urandom_range(0, 11));
      write_ppn    = 8'($urandom);
      write_asid   = 8'($urandom_range(0, 3));
      write_global = ($urandom_range(0, 5) == 0);
      flush_all     = ($urandom_range(0, 59) == 0);
      flush_asid_en = ($urandom_range(0, 19) == 0);
      flush_asid    = 8'($urandom_range(0, 3));
      tick();
      checks++;
      if (resp_valid !== exp_rv || hit !== exp_hit || miss !== exp_miss || paddr !== exp_paddr || occupancy !== 5'(exp_occ)) begin
        errors++;
        $display("FAIL random_c%0d: got rv=%b hit=%b miss=%b paddr=%h occ=%0d want rv=%b hit=%b miss=%b paddr=%h occ=%0d",
                 c, resp_valid, hit, miss, paddr, occupancy, exp_rv, exp_hit, exp_miss, exp_paddr, exp_occ);
      end
    end
  endtask

  initial begin
    idle_inputs();
    foreach (tbl[i]) tbl[i] = '{0, 0, 0, 0, 0, 0};
    exp_rv = 0; exp_hit = 0; exp_miss = 0; exp_paddr = '0; exp_occ = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_first_miss();
    test_refill_hit();
    test_replacement();
    test_overwrite();
    test_flush();
    test_supervisor();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
